// File: rtl/ham74_scrub_ctrl.sv
// Background scrubber for Hamming(7,4) protected memory: reads each word in turn,
// corrects any single-bit error and writes the fixed codeword back.
module ham74_scrub_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int IVL_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [IVL_W-1:0]  interval,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:1]        mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [7:1]        mem_rdata,
    output logic              busy,
    output logic              err_pulse,
    output logic [ADDR_W-1:0] err_addr,
    output logic [15:0]       corr_count,
    output logic              pass_done,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_READ  = 3'd2,
        S_RWAIT = 3'd3,
        S_CHECK = 3'd4,
        S_WRITE = 3'd5,
        S_NEXT  = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [IVL_W-1:0]  cnt_q, cnt_d;
    logic [7:1]        rdata_q, rdata_d;
    logic [7:1]        wdata_q, wdata_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [15:0]       corr_count_q, corr_count_d;
    logic              err_pulse_q, err_pulse_d;
    logic              pass_done_q, pass_done_d;

    logic [2:0]        syndrome;
    logic [7:1]        flip;

    // Syndrome {s1,s2,s3} of the registered word and the single bit it points at.
    always_comb begin
        syndrome = {rdata_q[7] ^ rdata_q[5] ^ rdata_q[3] ^ rdata_q[1],
                    rdata_q[6] ^ rdata_q[5] ^ rdata_q[2] ^ rdata_q[1],
                    rdata_q[4] ^ rdata_q[3] ^ rdata_q[2] ^ rdata_q[1]};
        flip = '0;
        case (syndrome)
            3'b100:  flip[7] = 1'b1;
            3'b010:  flip[6] = 1'b1;
            3'b110:  flip[5] = 1'b1;
            3'b001:  flip[4] = 1'b1;
            3'b101:  flip[3] = 1'b1;
            3'b011:  flip[2] = 1'b1;
            3'b111:  flip[1] = 1'b1;
            default: flip    = '0;
        endcase
    end

    // Memory handshake: mem_req, mem_we, mem_addr and mem_wdata are held stable from
    // the first request cycle until a cycle with mem_gnt high; that cycle is the transfer.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        wdata_d      = wdata_q;
        err_addr_d   = err_addr_q;
        corr_count_d = corr_count_q;
        err_pulse_d  = 1'b0;
        pass_done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_WAIT;
                    cnt_d   = interval;
                end
            end
            S_WAIT: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_READ;
                end else begin
                    cnt_d = cnt_q - IVL_W'(1);
                end
            end
            S_READ: begin
                if (mem_gnt) begin
                    state_d = S_RWAIT;
                end
            end
            S_RWAIT: begin
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (syndrome == 3'b000) begin
                    state_d = S_NEXT;
                end else begin
                    wdata_d = rdata_q ^ flip;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (mem_gnt) begin
                    err_pulse_d = 1'b1;
                    err_addr_d  = addr_q;
                    if (corr_count_q != 16'hFFFF) begin
                        corr_count_d = corr_count_q + 16'd1;
                    end
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d      = '0;
                    pass_done_d = 1'b1;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
                state_d = S_WAIT;
                cnt_d   = interval;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            wdata_q      <= '0;
            err_addr_q   <= '0;
            corr_count_q <= '0;
            err_pulse_q  <= 1'b0;
            pass_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            wdata_q      <= wdata_d;
            err_addr_q   <= err_addr_d;
            corr_count_q <= corr_count_d;
            err_pulse_q  <= err_pulse_d;
            pass_done_q  <= pass_done_d;
        end
    end

    assign mem_req    = (state_q == S_READ) || (state_q == S_WRITE);
    assign mem_we     = (state_q == S_WRITE);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = (state_q != S_IDLE);
    assign err_pulse  = err_pulse_q;
    assign err_addr   = err_addr_q;
    assign corr_count = corr_count_q;
    assign pass_done  = pass_done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ham74_scrub_ctrl.sv
// Directed bench for ham74_scrub_ctrl with an 8-word memory model and hand-computed codewords.
module tb_ham74_scrub_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  interval;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [7:1]  mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid = 1'b0;
    logic [7:1]  mem_rdata  = '0;
    logic        busy;
    logic        err_pulse;
    logic [3:0]  err_addr;
    logic [15:0] corr_count;
    logic        pass_done;
    logic [2:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    // Valid codewords {p1,p2,d1,p3,d2,d3,d4}, computed by hand.
    localparam logic [7:1] CLEAN [8] = '{7'b0000000, 7'b1101001, 7'b0100101, 7'b1011010,
                                         7'b1111111, 7'b1010101, 7'b1110000, 7'b1100110};

    logic [7:1]  img [8];
    logic [7:1]  mem [8];
    int          load_seq = 0;
    int          last_seq = 0;
    int          cyc      = 0;
    logic [3:0]  rd_log [$];
    int          rd_cyc [$];
    logic [10:0] wr_log [$];
    logic [10:0] exp_q  [$];
    logic [15:0] cc_log [$];
    int          err_n  = 0;
    int          pass_n = 0;

    ham74_scrub_ctrl #(.ADDR_W(4), .DEPTH(8), .IVL_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .interval   (interval),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .err_pulse  (err_pulse),
        .err_addr   (err_addr),
        .corr_count (corr_count),
        .pass_done  (pass_done),
        .dbg_state  (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    // Memory model: 1-cycle read latency, logs every transfer
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load_seq != last_seq) begin
            mem      <= img;
            last_seq <= load_seq;
        end
        mem_rvalid <= 1'b0;
        if (mem_req && mem_gnt) begin
            if (mem_we) begin
                mem[mem_addr[2:0]] <= mem_wdata;
                wr_log.push_back({mem_addr, mem_wdata});
            end else begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= mem[mem_addr[2:0]];
                rd_log.push_back(mem_addr);
                rd_cyc.push_back(cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (err_pulse) begin
            err_n = err_n + 1;
            cc_log.push_back(corr_count);
        end
        if (pass_done) pass_n = pass_n + 1;
    end

    // Checking and driver tasks
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_clean();
        for (int i = 0; i < 8; i++) img[i] = CLEAN[i];
    endtask

    task automatic load_img();
        load_seq++;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run_pass(input int budget);
        bit got;
        got = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (pass_done) begin
                got = 1'b1;
                break;
            end
        end
        en = 1'b0;
        check("pass_seen", {31'd0, got}, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic compare_writes(input int w0);
        check("wr_count", wr_log.size() - w0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (w0 + i < wr_log.size()) check("wr_data", {21'd0, wr_log[w0 + i]}, {21'd0, exp_q[i]});
        end
        exp_q.delete();
    endtask

    task automatic serve(input logic [3:0] a, input logic w, input int stall);
        bit         ok;
        int         bad;
        logic [3:0] sa;
        logic       sw;
        logic [7:1] sd;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (mem_req) begin
                ok = 1'b1;
                break;
            end
        end
        check("srv_req", {31'd0, ok}, 32'd1);
        check("srv_addr", {28'd0, mem_addr}, {28'd0, a});
        check("srv_we", {31'd0, mem_we}, {31'd0, w});
        sa  = mem_addr;
        sw  = mem_we;
        sd  = mem_wdata;
        bad = 0;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            if (!mem_req || mem_addr != sa || mem_we != sw || mem_wdata != sd) bad++;
        end
        if (stall > 0) check("srv_stable", bad, 0);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
    endtask

    task automatic preload_ffe();
        @(negedge clk);
        force dut.corr_count_q = 16'hFFFE;
        #2;
        release dut.corr_count_q;
        @(negedge clk);
        check("preload", {16'd0, corr_count}, 32'h0000FFFE);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   {31'd0, mem_req}, 32'd0);
        check({tag, "_we"},    {31'd0, mem_we}, 32'd0);
        check({tag, "_addr"},  {28'd0, mem_addr}, 32'd0);
        check({tag, "_wdata"}, {25'd0, mem_wdata}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_errp"},  {31'd0, err_pulse}, 32'd0);
        check({tag, "_pass"},  {31'd0, pass_done}, 32'd0);
        check({tag, "_eaddr"}, {28'd0, err_addr}, 32'd0);
        check({tag, "_cnt"},   {16'd0, corr_count}, 32'd0);
        check({tag, "_state"}, {29'd0, dbg_state}, 32'd0);
    endtask

    // Main sequence
    initial begin
        int  r0, w0, p0, e0, c0, n3;
        bit  got;

        rst = 1'b1; en = 1'b0; interval = 8'd0; mem_gnt = 1'b1;
        set_clean();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // T1: clean memory, interval 0
        load_img();
        r0 = rd_log.size(); w0 = wr_log.size(); p0 = pass_n;
        en = 1'b1;
        run_pass(200);
        check("t1_reads", rd_log.size() - r0, 8);
        for (int i = 0; i < 8; i++) begin
            if (r0 + i < rd_log.size()) check("t1_addr", {28'd0, rd_log[r0 + i]}, i);
        end
        if (r0 + 1 < rd_cyc.size()) check("t1_gap", rd_cyc[r0 + 1] - rd_cyc[r0], 5);
        compare_writes(w0);
        check("t1_pass", pass_n - p0, 1);
        check("t1_cnt", {16'd0, corr_count}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd0);

        // T2: d1 error at addr 5, p1 error at addr 2
        set_clean();
        img[2] = 7'b0101001;
        img[5] = 7'b1000101;
        load_img();
        exp_q.push_back({4'd2, 7'b1101001});
        exp_q.push_back({4'd5, 7'b1010101});
        r0 = rd_log.size(); w0 = wr_log.size(); e0 = err_n;
        en = 1'b1;
        run_pass(200);
        compare_writes(w0);
        check("t2_pulses", err_n - e0, 2);
        check("t2_eaddr", {28'd0, err_addr}, 32'd5);
        check("t2_cnt", {16'd0, corr_count}, 32'd2);
        if (r0 + 3 < rd_cyc.size()) check("t2_gap", rd_cyc[r0 + 3] - rd_cyc[r0 + 2], 6);

        // T3: grant withheld 10 cycles in READ and WRITE of addr 3
        set_clean();
        img[3] = 7'b1011011;
        load_img();
        exp_q.push_back({4'd3, 7'b1011010});
        r0 = rd_log.size(); w0 = wr_log.size();
        mem_gnt = 1'b0;
        en = 1'b1;
        serve(4'd0, 1'b0, 0);
        serve(4'd1, 1'b0, 0);
        serve(4'd2, 1'b0, 0);
        serve(4'd3, 1'b0, 10);
        serve(4'd3, 1'b1, 10);
        mem_gnt = 1'b1;
        run_pass(200);
        n3 = 0;
        for (int i = r0; i < rd_log.size(); i++) if (rd_log[i] == 4'd3) n3++;
        check("t3_rd3", n3, 1);
        check("t3_reads", rd_log.size() - r0, 8);
        compare_writes(w0);

        // T4: en dropped in RWAIT of addr 1
        set_clean();
        img[1] = 7'b0100100;
        load_img();
        exp_q.push_back({4'd1, 7'b0100101});
        r0 = rd_log.size(); w0 = wr_log.size(); p0 = pass_n;
        en = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (mem_req && !mem_we && mem_addr == 4'd1) begin
                got = 1'b1;
                break;
            end
        end
        check("t4_rd1", {31'd0, got}, 32'd1);
        @(negedge clk);
        check("t4_rwait", {29'd0, dbg_state}, 32'd3);
        en = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!busy) begin
                got = 1'b1;
                break;
            end
        end
        check("t4_idle", {31'd0, got}, 32'd1);
        check("t4_state", {29'd0, dbg_state}, 32'd0);
        check("t4_reads", rd_log.size() - r0, 2);
        check("t4_pass", pass_n - p0, 0);
        compare_writes(w0);

        // T5: reset while WRITE of addr 2 is stalled, counter at FFFE
        set_clean();
        img[2] = 7'b0101101;
        load_img();
        preload_ffe();
        w0 = wr_log.size();
        mem_gnt = 1'b0;
        en = 1'b1;
        serve(4'd2, 1'b0, 0);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_req && mem_we) begin
                got = 1'b1;
                break;
            end
        end
        check("t5_write_req", {31'd0, got}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        check_reset_outputs("t5");
        rst = 1'b0;
        mem_gnt = 1'b1;
        repeat (5) @(negedge clk);
        compare_writes(w0);

        // T6: saturation from FFFE, interval 3
        set_clean();
        img[0] = 7'b0000001;
        img[1] = 7'b0100100;
        load_img();
        preload_ffe();
        exp_q.push_back({4'd0, 7'b0000000});
        exp_q.push_back({4'd1, 7'b0100101});
        r0 = rd_log.size(); w0 = wr_log.size(); e0 = err_n; c0 = cc_log.size();
        interval = 8'd3;
        en = 1'b1;
        run_pass(400);
        compare_writes(w0);
        check("t6_pulses", err_n - e0, 2);
        if (c0 + 1 < cc_log.size()) begin
            check("t6_cc0", {16'd0, cc_log[c0]}, 32'h0000FFFF);
            check("t6_cc1", {16'd0, cc_log[c0 + 1]}, 32'h0000FFFF);
        end
        check("t6_cnt", {16'd0, corr_count}, 32'h0000FFFF);
        check("t6_eaddr", {28'd0, err_addr}, 32'd1);
        if (r0 + 3 < rd_cyc.size()) check("t6_gap", rd_cyc[r0 + 3] - rd_cyc[r0 + 2], 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
